pipelined_mult_ci: RTL and testbench
====================================

Name: pipelined_mult_ci

Overview:
- Parametrised multi-cycle integer multiplier with a Nios II custom-instruction style start/done handshake.
- Successor to the combinational 32x32 LPM_MULT block: generalised width, radix (bits retired per cycle), signed/unsigned operation, and low/high product-half selection.
- Sits on the processor custom-instruction port of the Cyclone V function accelerator.

Parameters:
- WIDTH, 32: operand and result width in bits; must be even and >= 4.
- BPC, 1: multiplier bits retired per cycle; legal values 1, 2, 4; WIDTH % BPC == 0.
- N (local), WIDTH/BPC: number of iteration cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  when low, every register holds its value, including state, counter and outputs.
- start  in  1  one-cycle request; sampled when clk_en=1.
- n  in  2  mode, captured with start: 0=unsigned low half, 1=unsigned high half, 2=signed low half, 3=signed high half.
- dataa  in  WIDTH  multiplicand, captured with start.
- datab  in  WIDTH  multiplier, captured with start.
- result  out  WIDTH  selected half of the 2*WIDTH product; registered.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset (async, reset_n=0):
  - result=0, done=0, busy=0, state=IDLE.
  - Internal accumulator and counter cleared.
  - Asserting reset mid-operation aborts the operation; no done is issued.
- States:
  - IDLE -> CALC on start.
  - CALC -> FIN when the counter reaches N-1.
  - FIN -> IDLE unconditionally.
- Load (edge E0, IDLE, start=1):
  - Latch mode.
  - Store |dataa| and |datab| when signed, else raw values.
  - Store neg = signed & (a_msb ^ b_msb).
  - Clear the 2*WIDTH accumulator; counter=0; busy=1.
- CALC (edges E1..EN):
  - Each edge adds (multiplicand * BPC-bit slice of multiplier) into the accumulator using shift-add, LSB slice first.
  - Counter increments each edge.
  - Unsigned arithmetic on magnitudes, 2*WIDTH-bit wide; no overflow is possible.
- FIN (edge E(N+1)):
  - p = neg ? -acc : acc (two's complement, 2*WIDTH bits).
  - result <= p[WIDTH-1:0] for mode 0/2, p[2W-1:W] for mode 1/3.
  - done <= 1 and busy <= 0 at the same edge.
- Latency: done is high in the cycle following E(N+1), i.e. N+1 clk_en-qualified cycles after start is sampled. WIDTH=32, BPC=1 gives 33; BPC=4 gives 9.
- done is low in every other cycle.
- result holds its value until the next FIN; it is not cleared by done falling.
- start while busy=1 is ignored: no queuing, and captured operands are unaffected.
- start in the done cycle (state IDLE) is accepted, giving back-to-back operation.
- Signed corner: 0x80000000 magnitude stays 0x80000000 as unsigned WIDTH-bit; the product is exact.
- clk_en=0 at any point stretches latency by exactly the number of stalled cycles; done stays registered high across a stall in its cycle.

Test Plan:
- Reset, then mode 0, dataa=332, datab=22, BPC=1 -> done exactly 33 cycles after start; result=7304 (0x1C88); busy low in the done cycle.
- Mode 1 and mode 0 on 0xFFFFFFFF x 0xFFFFFFFF -> high half 0xFFFFFFFE, low half 0x00000001.
- Mode 2/3 on -3 x 5 -> low 0xFFFFFFF1, high 0xFFFFFFFF.
- Mode 3 on 0x80000000 x 0x80000000 -> 0x40000000; mode 2 on the same -> 0x00000000.
- start re-pulsed mid-CALC with different operands -> ignored, original result delivered. Back-to-back start in the done cycle (1 x 2, then 2 x 23) -> second done 33 cycles later, result=46.
- Two async resets: reset_n pulled low at cycle 10 of an operation -> outputs 0 immediately, no done. Then 5 cycles of clk_en=0 mid-CALC -> done delayed by exactly 5 cycles, result correct.

Source files
------------

// File: rtl/pipelined_mult_ci_if.sv
// ============================================================================
// Module   : pipelined_mult_ci_if
// Brief    : Custom-instruction request/response bundle for pipelined_mult_ci.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_mult_ci_if #(
  parameter int WIDTH = 32
);
  logic             clk_en;
  logic             start;
  logic [1:0]       n;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  result, done, busy
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output result, done, busy
  );
endinterface

`default_nettype wire

// File: rtl/pipelined_mult_ci.sv
// ============================================================================
// Module   : pipelined_mult_ci
// Brief    : Iterative shift-add multiplier, BPC multiplier bits per cycle,
//            signed/unsigned with low/high product-half select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_mult_ci #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  pipelined_mult_ci_if.slave bus
);

  localparam int              c_N    = WIDTH / BPC;
  localparam int              c_CW   = $clog2(c_N) + 1;
  localparam int              c_PW   = 2 * WIDTH;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic              r_neg;
  logic [c_PW-1:0]   r_mcand;
  logic [c_PW-1:0]   r_acc;
  logic [WIDTH-1:0]  r_mplier;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_result;
  logic              r_done;
  logic              r_busy;

  logic              w_signed_in;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [c_PW-1:0]   w_partial;
  logic [c_PW-1:0]   w_prod;

  // Magnitude of the most negative value wraps to itself, which is exactly
  // the right unsigned magnitude.
  assign w_signed_in = bus.n[1];
  assign w_mag_a     = (w_signed_in && bus.dataa[WIDTH-1]) ? -bus.dataa : bus.dataa;
  assign w_mag_b     = (w_signed_in && bus.datab[WIDTH-1]) ? -bus.datab : bus.datab;

  always_comb begin
    w_partial = '0;
    for (int b = 0; b < BPC; b++) begin
      if (r_mplier[b]) begin
        w_partial = w_partial + (r_mcand << b);
      end
    end
  end

  assign w_prod = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else if (bus.clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = CALC;
      CALC:    if (r_cnt == c_LAST) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode   <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (bus.clk_en) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mode   <= bus.n;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_neg    <= w_signed_in & (bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        CALC: begin
          // Multiplicand walks left while the multiplier walks right, so the
          // low BPC bits of r_mplier are always the current slice.
          r_acc    <= r_acc + w_partial;
          r_mcand  <= r_mcand << BPC;
          r_mplier <= r_mplier >> BPC;
          r_cnt    <= r_cnt + 1'b1;
        end
        FIN: begin
          r_result <= r_mode[0] ? w_prod[c_PW-1:WIDTH] : w_prod[WIDTH-1:0];
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_mult_ci.sv
// ============================================================================
// Module   : tb_pipelined_mult_ci
// Brief    : Scoreboard bench for pipelined_mult_ci (directed + random ops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_mult_ci;
  localparam int W   = 32;
  localparam int BPC = 1;
  localparam int N   = W / BPC;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_en_q[$];
  int           en_cnt        = 0;
  int           cyc           = 0;
  int           last_done_cyc = 0;
  int           issue_cyc     = 0;
  logic         last_en       = 1'b0;

  pipelined_mult_ci_if #(.WIDTH(W)) bus ();

  pipelined_mult_ci #(.WIDTH(W), .BPC(BPC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    last_en <= bus.clk_en;
    if (bus.clk_en && reset_n) en_cnt <= en_cnt + 1;
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] mode);
    logic [2*W-1:0] p;
    if (mode[1]) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return mode[0] ? p[2*W-1:W] : p[W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per done pulse; a stalled done cycle is not re-counted.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    int           el;
    if (reset_n && bus.done && last_en) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e  = exp_q.pop_front();
        el = exp_en_q.pop_front();
        check("result", bus.result, e);
        check("latency_en", en_cnt, el);
        check("busy_in_done", bus.busy, 0);
      end
    end
  end

  // Called at negedge+1; start is sampled at the following rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] mode, input logic [W-1:0] exp);
    bus.start = 1'b1;
    bus.dataa = a;
    bus.datab = b;
    bus.n     = mode;
    exp_q.push_back(exp);
    exp_en_q.push_back(en_cnt + N + 2);
    issue_cyc = cyc;
    @(negedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
      exp_q.delete();
      exp_en_q.delete();
    end
  endtask

  initial begin
    int             stall_issue;
    logic [W-1:0]   a, b;
    logic [1:0]     m;
    int             gap;

    bus.clk_en = 1'b1;
    bus.start  = 1'b0;
    bus.n      = 2'd0;
    bus.dataa  = '0;
    bus.datab  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", bus.result, 0);
    check("reset_done", bus.done, 0);
    check("reset_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(negedge clk); #1;

    issue(32'd332, 32'd22, 2'd0, 32'h0000_1C88);
    wait_drain(60);
    check("latency_cyc", last_done_cyc - issue_cyc, N + 2);

    // Directed corners, each issued in the previous done cycle.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFE); wait_drain(60);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001); wait_drain(60);
    issue(-32'sd3,       32'd5,         2'd2, 32'hFFFF_FFF1); wait_drain(60);
    issue(-32'sd3,       32'd5,         2'd3, 32'hFFFF_FFFF); wait_drain(60);
    issue(32'h8000_0000, 32'h8000_0000, 2'd3, 32'h4000_0000); wait_drain(60);
    issue(32'h8000_0000, 32'h8000_0000, 2'd2, 32'h0000_0000); wait_drain(60);

    // Restart while busy must be ignored.
    issue(32'd1234, 32'd5678, 2'd0, 32'd7006652);
    repeat (5) @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.dataa = 32'd999;
    bus.datab = 32'd7;
    bus.n     = 2'd1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    wait_drain(60);

    issue(32'd1, 32'd2, 2'd0, 32'd2);
    wait_drain(60);
    issue(32'd2, 32'd23, 2'd0, 32'd46);
    wait_drain(60);
    check("b2b_latency_cyc", last_done_cyc - issue_cyc, N + 2);

    // Async abort mid-operation.
    issue(32'd100, 32'd200, 2'd0, 32'd20000);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    exp_en_q.delete();
    #1;
    check("abort_result", bus.result, 0);
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (N + 10) @(negedge clk);
    #1;
    check("busy_after_abort", bus.busy, 0);

    // Five stalled cycles mid-CALC.
    issue(32'h1234_5678, 32'h0000_9ABC, 2'd0, model(32'h1234_5678, 32'h0000_9ABC, 2'd0));
    stall_issue = issue_cyc;
    repeat (10) @(negedge clk);
    #1;
    bus.clk_en = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    bus.clk_en = 1'b1;
    wait_drain(80);
    check("stall_latency_cyc", last_done_cyc - stall_issue, N + 2 + 5);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      m = 2'($urandom_range(0, 3));
      if (i % 6 == 0) a = 32'h8000_0000;
      if (i % 8 == 3) b = 32'hFFFF_FFFF;
      issue(a, b, m, model(a, b, m));
      wait_drain(60);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk); #1;
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
